// File: rtl/vcr_pwm_sequencer_if.sv
// Control/status bundle between a host and vcr_pwm_sequencer.
// The master drives the duty, enable and comparator inputs; the slave (the sequencer) drives the PWM and mux outputs.
interface vcr_pwm_sequencer_if;
  logic       ena;
  logic [7:0] duty_in;
  logic       duty_ld;
  logic       comp_in;
  logic       fault_clr;
  logic       led_en;
  logic [1:0] mux_sel;
  logic       latch_s;
  logic       fault;
  logic [1:0] state_o;

  modport master (
    output ena, duty_in, duty_ld, comp_in, fault_clr,
    input  led_en, mux_sel, latch_s, fault, state_o
  );

  modport slave (
    input  ena, duty_in, duty_ld, comp_in, fault_clr,
    output led_en, mux_sel, latch_s, fault, state_o
  );
endinterface

// File: rtl/vcr_pwm_sequencer.sv
// LED PWM sequencer with debounced overcurrent trip, analog mux stepping and fault handling.
// Define VCR_FAULT_LATCH_EN to make FAULT sticky until fault_clr; otherwise it auto-retries after RETRY_CYCLES.
module vcr_pwm_sequencer #(
  parameter int DEBOUNCE_LEN = 4,
  parameter int RETRY_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vcr_pwm_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_sync1, r_sync2;
  logic [3:0]  r_db_cnt, w_db_cnt_next;
  logic [7:0]  r_shadow, w_shadow_next;
  logic [7:0]  r_active, w_active_next;
  logic [7:0]  r_pwm_cnt, w_pwm_cnt_next;
  logic [1:0]  r_mux_sel, w_mux_sel_next;
  logic        r_led_en, w_led_en_next;
  logic        r_latch_s, w_latch_s_next;
  logic [15:0] r_dwell, w_dwell_next;
  logic        w_comp_db;

`ifndef VCR_FAULT_LATCH_EN
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = bus.fault_clr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db_cnt  <= '0;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pwm_cnt <= '0;
      r_mux_sel <= '0;
      r_led_en  <= 1'b0;
      r_latch_s <= 1'b0;
      r_dwell   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_sync1   <= bus.comp_in;
      r_sync2   <= r_sync1;
      r_db_cnt  <= w_db_cnt_next;
      r_shadow  <= w_shadow_next;
      r_active  <= w_active_next;
      r_pwm_cnt <= w_pwm_cnt_next;
      r_mux_sel <= w_mux_sel_next;
      r_led_en  <= w_led_en_next;
      r_latch_s <= w_latch_s_next;
      r_dwell   <= w_dwell_next;
    end
  end

  // Consecutive-high counter saturates so comp_db stays asserted while the comparator holds.
  always_comb begin
    w_db_cnt_next = '0;
    if (r_sync2) begin
      w_db_cnt_next = (r_db_cnt == 4'(DEBOUNCE_LEN)) ? r_db_cnt : r_db_cnt + 4'd1;
    end
  end

  assign w_comp_db     = (r_db_cnt == 4'(DEBOUNCE_LEN));
  assign w_shadow_next = bus.duty_ld ? bus.duty_in : r_shadow;

  always_comb begin
    w_state_next   = r_state;
    w_pwm_cnt_next = r_pwm_cnt;
    w_active_next  = r_active;
    w_mux_sel_next = r_mux_sel;
    w_led_en_next  = 1'b0;
    w_latch_s_next = 1'b0;
    w_dwell_next   = r_dwell;

    if (!bus.ena) begin
      w_state_next   = ST_IDLE;
      w_pwm_cnt_next = '0;
      w_mux_sel_next = '0;
      w_dwell_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next   = ST_RUN;
          w_pwm_cnt_next = '0;
          w_mux_sel_next = '0;
          w_active_next  = r_shadow;
          w_dwell_next   = '0;
        end
        ST_RUN: begin
          if (w_comp_db) begin
            w_state_next   = ST_FAULT;
            w_latch_s_next = 1'b1;
            w_dwell_next   = '0;
          end else begin
            w_pwm_cnt_next = r_pwm_cnt + 8'd1;
            w_led_en_next  = (r_pwm_cnt < r_active);
            // Old shadow goes active at the wrap, so a coincident duty_ld lands one period later.
            if (r_pwm_cnt == 8'hFF) begin
              w_active_next  = r_shadow;
              w_mux_sel_next = r_mux_sel + 2'd1;
            end
          end
        end
        ST_FAULT: begin
`ifdef VCR_FAULT_LATCH_EN
          if (bus.fault_clr && !w_comp_db) begin
            w_state_next   = ST_RUN;
            w_pwm_cnt_next = '0;
            w_active_next  = r_shadow;
          end
`else
          if (r_dwell == 16'(RETRY_CYCLES - 1)) begin
            w_state_next   = ST_RUN;
            w_pwm_cnt_next = '0;
            w_active_next  = r_shadow;
            w_dwell_next   = '0;
          end else begin
            w_dwell_next = r_dwell + 16'd1;
          end
`endif
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign bus.led_en  = r_led_en;
  assign bus.mux_sel = r_mux_sel;
  assign bus.latch_s = r_latch_s;
  assign bus.fault   = (r_state == ST_FAULT);
  assign bus.state_o = r_state;

endmodule

// File: tb/tb_vcr_pwm_sequencer.sv
// Directed bench for vcr_pwm_sequencer: duty periods, mux stepping, debounce, fault exit, ena drop and async reset.
// Build with VCR_FAULT_LATCH_EN defined to exercise the sticky-fault variant.
module tb_vcr_pwm_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vcr_pwm_sequencer_if bus_if ();

  vcr_pwm_sequencer #(
    .DEBOUNCE_LEN (4),
    .RETRY_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp_v);
    end else begin
      $display("[TB] ok   %s = %0d", tag, act);
    end
  endtask

  // One 256-cycle PWM period; optionally strobe duty_ld after sample load_at.
  task automatic run_period(input int load_at, input logic [7:0] val, output int highs);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (bus_if.led_en === 1'b1) highs++;
      if (i == load_at) begin
        bus_if.duty_in = val;
        bus_if.duty_ld = 1'b1;
      end else if (i == load_at + 1) begin
        bus_if.duty_ld = 1'b0;
      end
    end
  endtask

  int         ld_at  [9] = '{-1, -1, 100, -1, 254, -1, 10, 10, -1};
  logic [7:0] ld_val [9] = '{8'd0, 8'd0, 8'd192, 8'd0, 8'd32, 8'd0, 8'd255, 8'd0, 8'd0};
  int         exp_hi [9] = '{64, 64, 64, 192, 192, 192, 32, 255, 0};

  int highs;
  int cnt;

  initial begin
    rst_n            = 1'b0;
    bus_if.ena       = 1'b0;
    bus_if.duty_in   = 8'd0;
    bus_if.duty_ld   = 1'b0;
    bus_if.comp_in   = 1'b0;
    bus_if.fault_clr = 1'b0;

    repeat (2) @(negedge clk);
    check_val("reset_state", 32'(bus_if.state_o), 0);
    check_val("reset_led", 32'(bus_if.led_en), 0);
    check_val("reset_mux", 32'(bus_if.mux_sel), 0);
    check_val("reset_latch", 32'(bus_if.latch_s), 0);
    check_val("reset_fault", 32'(bus_if.fault), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_without_ena", 32'(bus_if.state_o), 0);

    bus_if.duty_in = 8'd64;
    bus_if.duty_ld = 1'b1;
    @(negedge clk);
    bus_if.duty_ld = 1'b0;
    bus_if.ena     = 1'b1;
    @(negedge clk);
    check_val("entry_state", 32'(bus_if.state_o), 1);
    check_val("entry_mux", 32'(bus_if.mux_sel), 0);
    check_val("entry_led", 32'(bus_if.led_en), 0);

    for (int p = 0; p < 9; p++) begin
      run_period(ld_at[p], ld_val[p], highs);
      check_val($sformatf("period%0d_highs", p + 1), 32'(highs), 32'(exp_hi[p]));
      check_val($sformatf("period%0d_mux", p + 1), 32'(bus_if.mux_sel), 32'((p + 1) % 4));
    end

    bus_if.duty_in = 8'd128;
    bus_if.duty_ld = 1'b1;
    @(negedge clk);
    bus_if.duty_ld = 1'b0;
    @(negedge clk);

    bus_if.comp_in = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.comp_in = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.fault === 1'b1) cnt++;
    end
    check_val("short_pulse_no_fault", 32'(cnt), 0);

    bus_if.comp_in = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check_val("edge6_no_fault", 32'(bus_if.fault), 0);
    end
    check_val("edge7_fault", 32'(bus_if.fault), 1);
    check_val("edge7_state", 32'(bus_if.state_o), 2);
    check_val("edge7_latch", 32'(bus_if.latch_s), 1);
    check_val("edge7_led", 32'(bus_if.led_en), 0);

`ifndef VCR_FAULT_LATCH_EN
    bus_if.comp_in = 1'b0;
    cnt = 0;
    for (int k = 8; k <= 23; k++) begin
      @(negedge clk);
      if (bus_if.latch_s === 1'b1) cnt++;
      if (k == 22) check_val("dwell_hold_state", 32'(bus_if.state_o), 2);
    end
    check_val("retry_state", 32'(bus_if.state_o), 1);
    check_val("retry_latch_pulses", 32'(cnt), 0);
`else
    bus_if.fault_clr = 1'b1;
    repeat (10) @(negedge clk);
    check_val("clr_ignored_state", 32'(bus_if.state_o), 2);
    bus_if.fault_clr = 1'b0;
    bus_if.comp_in   = 1'b0;
    repeat (20) @(negedge clk);
    check_val("no_auto_retry_state", 32'(bus_if.state_o), 2);
    bus_if.fault_clr = 1'b1;
    @(negedge clk);
    bus_if.fault_clr = 1'b0;
    check_val("clr_exit_state", 32'(bus_if.state_o), 1);
`endif
    check_val("fault_exit_mux_kept", 32'(bus_if.mux_sel), 1);
    run_period(-1, 8'd0, highs);
    check_val("post_fault_highs", 32'(highs), 128);
    check_val("post_fault_mux", 32'(bus_if.mux_sel), 2);

    bus_if.comp_in = 1'b1;
    repeat (7) @(negedge clk);
    check_val("refault_state", 32'(bus_if.state_o), 2);
    bus_if.ena = 1'b0;
    @(negedge clk);
    check_val("ena_drop_state", 32'(bus_if.state_o), 0);
    check_val("ena_drop_led", 32'(bus_if.led_en), 0);
    check_val("ena_drop_latch", 32'(bus_if.latch_s), 0);
    check_val("ena_drop_mux", 32'(bus_if.mux_sel), 0);
    check_val("ena_drop_fault", 32'(bus_if.fault), 0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.latch_s === 1'b1) cnt++;
    end
    check_val("idle_latch_pulses", 32'(cnt), 0);
    bus_if.comp_in = 1'b0;

    bus_if.ena = 1'b1;
    @(negedge clk);
    repeat (300) @(negedge clk);
    check_val("pre_reset_mux", 32'(bus_if.mux_sel), 1);
    check_val("pre_reset_led", 32'(bus_if.led_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_reset_state", 32'(bus_if.state_o), 0);
    check_val("async_reset_led", 32'(bus_if.led_en), 0);
    check_val("async_reset_mux", 32'(bus_if.mux_sel), 0);
    check_val("async_reset_latch", 32'(bus_if.latch_s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_reset_run", 32'(bus_if.state_o), 1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.led_en === 1'b1) cnt++;
    end
    check_val("post_reset_duty_zero", 32'(cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
